// File: rtl/r_type_pkg.sv
// rtl/r_type_pkg.sv - shared types and constants for the R-type execute arbiter
package r_type_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam int         ALU_W     = 32;
    localparam int         TAG_W_MAX = 16;

    typedef enum logic [2:0] {
        ADD_SUB = 3'd0,
        SLL     = 3'd1,
        SLT     = 3'd2,
        SLTU    = 3'd3,
        XOR     = 3'd4,
        SRL_SRA = 3'd5,
        OR      = 3'd6,
        AND     = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Tag is stored at its widest and narrowed at the response port.
    typedef struct packed {
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [ALU_W-1:0]     in1;
        logic [ALU_W-1:0]     in2;
        logic [TAG_W_MAX-1:0] tag;
        logic                 id;
    } op_t;

    function automatic logic is_legal(input logic [2:0] f3, input logic [6:0] f7);
        return (f7 == F7_BASE) ||
               ((f7 == F7_ALT) && ((f3 == ADD_SUB) || (f3 == SRL_SRA)));
    endfunction

endpackage

// File: rtl/r_type.sv
// rtl/r_type.sv - combinational 32-bit R-type ALU
module r_type
    import r_type_pkg::*;
(
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [ALU_W-1:0] in1,
    input  logic [ALU_W-1:0] in2,
    output logic [ALU_W-1:0] result
);

    logic       alt;
    logic [4:0] shamt;

    assign alt   = (funct7 == F7_ALT);
    assign shamt = in2[4:0];

    always_comb begin
        result = '0;
        if (opcode == OP_R) begin
            case (funct3_e'(funct3))
                ADD_SUB: result = alt ? (in1 - in2) : (in1 + in2);
                SLL:     result = in1 << shamt;
                SLT:     result = {31'b0, ($signed(in1) < $signed(in2))};
                SLTU:    result = {31'b0, (in1 < in2)};
                XOR:     result = in1 ^ in2;
                SRL_SRA: result = alt ? $unsigned($signed(in1) >>> shamt) : (in1 >> shamt);
                OR:      result = in1 | in2;
                AND:     result = in1 & in2;
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/r_type_exec_arbiter.sv
// rtl/r_type_exec_arbiter.sv - round-robin sharing of one R-type ALU between two requesters
module r_type_exec_arbiter
    import r_type_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][2:0]       req_funct3,
    input  logic [1:0][6:0]       req_funct7,
    input  logic [1:0][XLEN-1:0]  req_in1,
    input  logic [1:0][XLEN-1:0]  req_in2,
    input  logic [1:0][TAG_W-1:0] req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [XLEN-1:0]       rsp_result,
    output logic                  rsp_err,
    output logic                  busy
);

    state_e          state_q, state_d;
    logic            last_grant;
    logic            grant;
    logic            accept;
    op_t             op_q, op_d;
    logic [ALU_W-1:0] alu_result;
    logic            op_legal;

    // Ties go to whoever did not win last; reset leaves last_grant=1 so 0 wins first.
    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

    assign accept = (state_q == IDLE) && (req_valid != 2'b00);

    always_comb begin
        op_d.funct3 = req_funct3[grant];
        op_d.funct7 = req_funct7[grant];
        op_d.in1    = req_in1[grant];
        op_d.in2    = req_in2[grant];
        op_d.tag    = TAG_W_MAX'(req_tag[grant]);
        op_d.id     = grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        rsp_valid = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
                if (accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    r_type u_alu (
        .opcode (OP_R),
        .funct3 (op_q.funct3),
        .funct7 (op_q.funct7),
        .in1    (op_q.in1),
        .in2    (op_q.in2),
        .result (alu_result)
    );

    assign op_legal = is_legal(op_q.funct3, op_q.funct7);

    // Response fields are only written in EXEC, so they stay frozen through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            op_q       <= '0;
            rsp_id     <= 1'b0;
            rsp_tag    <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q       <= op_d;
                        last_grant <= grant;
                    end
                end
                EXEC: begin
                    rsp_id     <= op_q.id;
                    rsp_tag    <= op_q.tag[TAG_W-1:0];
                    rsp_err    <= ~op_legal;
                    rsp_result <= op_legal ? alu_result : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_r_type_exec_arbiter.sv
// tb/tb_r_type_exec_arbiter.sv - self-checking bench for r_type_exec_arbiter
module tb_r_type_exec_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][2:0]  req_funct3;
    logic [1:0][6:0]  req_funct7;
    logic [1:0][31:0] req_in1;
    logic [1:0][31:0] req_in2;
    logic [1:0][3:0]  req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [3:0]       rsp_tag;
    logic [31:0]      rsp_result;
    logic             rsp_err;
    logic             busy;

    int checks = 0;
    int errors = 0;

    r_type_exec_arbiter #(.XLEN(32), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        id;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        id;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        err;
    } exp_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU straight from the instruction-set rules.
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] a, input logic [31:0] b,
                                            output logic err);
        int unsigned s;
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        s    = int'(b % 32);
        err  = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        if (err) return 32'd0;
        case (f3)
            3'd0: return (f7 == 7'h00) ? a + b : a - b;
            3'd1: return a << s;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return (f7 == 7'h00) ? (a >> s) : ((a >> s) | (a[31] ? ~(ones >> s) : 32'd0));
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        req_valid[i]  = 1'b1;
        req_funct3[i] = f3;
        req_funct7[i] = f7;
        req_in1[i]    = a;
        req_in2[i]    = b;
        req_tag[i]    = tag;
    endtask

    task automatic wait_ready(input int i, input string name);
        int n = 0;
        while (!req_ready[i] && n < 20) begin
            tick();
            n++;
        end
        check(name, req_ready[i], 1'b1);
    endtask

    task automatic collect(input logic id, input logic [3:0] tag, input logic [31:0] res,
                           input logic err, input string name);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_valid"}, rsp_valid, 1'b1);
        check({name, "_id"}, rsp_id, id);
        check({name, "_tag"}, rsp_tag, tag);
        check({name, "_result"}, rsp_result, res);
        check({name, "_err"}, rsp_err, err);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({name, "_released"}, rsp_valid, 1'b0);
    endtask

    vec_t vecs[14];
    exp_t q[$];

    initial begin
        logic        eg;
        logic        mlast;
        logic        occ;
        int          age;
        logic [1:0]  exp_rdy;
        logic        e_err;
        logic [31:0] e_res;
        logic        fexp;
        logic        flast;
        logic [3:0]  ctag;
        logic [31:0] cin1;
        logic [3:0]  ftag [2];
        int          n;

        vecs[0]  = '{1'b0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'd1,         4'd3,  32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 3'd0, 7'h20, 32'd5,         32'd7,         4'd1,  32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{1'b0, 3'd5, 7'h20, 32'h8000_0000, 32'd4,         4'd2,  32'hF800_0000, 1'b0};
        vecs[3]  = '{1'b1, 3'd5, 7'h00, 32'h8000_0000, 32'd4,         4'd4,  32'h0800_0000, 1'b0};
        vecs[4]  = '{1'b0, 3'd1, 7'h00, 32'd1,         32'd33,        4'd5,  32'h0000_0002, 1'b0};
        vecs[5]  = '{1'b1, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1,         4'd6,  32'h0000_0001, 1'b0};
        vecs[6]  = '{1'b0, 3'd3, 7'h00, 32'd5,         32'd3,         4'd7,  32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1,         4'd8,  32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 3'd4, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd9,  32'h0FF0_0FF0, 1'b0};
        vecs[9]  = '{1'b1, 3'd6, 7'h00, 32'h1234_0000, 32'h0000_5678, 4'd10, 32'h1234_5678, 1'b0};
        vecs[10] = '{1'b0, 3'd7, 7'h00, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 4'd11, 32'h3030_3030, 1'b0};
        vecs[11] = '{1'b1, 3'd1, 7'h20, 32'h0000_00FF, 32'd1,         4'd12, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, 3'd3, 7'h00, 32'd1,         32'hFFFF_FFFF, 4'd13, 32'h0000_0001, 1'b0};
        vecs[13] = '{1'b1, 3'd0, 7'h01, 32'h7FFF_FFFF, 32'd1,         4'd14, 32'h0000_0000, 1'b1};

        rst_n = 1'b0; req_valid = '0; req_funct3 = '0; req_funct7 = '0;
        req_in1 = '0; req_in2 = '0; req_tag = '0; rsp_ready = 1'b0;
        tick();
        tick();
        check("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_err, busy}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 1'b0);
        check("idle_ready", req_ready, 2'b00);

        // Table of single operations, alternating requesters.
        foreach (vecs[i]) begin
            set_req(int'(vecs[i].id), vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, vecs[i].tag);
            #1;
            wait_ready(int'(vecs[i].id), $sformatf("vec%0d_ready", i));
            tick();
            req_valid = 2'b00;
            check($sformatf("vec%0d_exec_valid", i), rsp_valid, 1'b0);
            check($sformatf("vec%0d_exec_busy", i), busy, 1'b1);
            tick();
            check($sformatf("vec%0d_latency", i), rsp_valid, 1'b1);
            collect(vecs[i].id, vecs[i].tag, vecs[i].exp_res, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Simultaneous requests: 0 first, requester 1 held off until IDLE.
        set_req(0, 3'd0, 7'h20, 32'd5, 32'd7, 4'd1);
        set_req(1, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 4'd2);
        #1;
        check("tie_ready", req_ready, 2'b01);
        tick();
        req_valid[0] = 1'b0;
        check("tie_exec_ready", req_ready, 2'b00);
        tick();
        check("tie_resp_ready", req_ready, 2'b00);
        collect(1'b0, 4'd1, 32'hFFFF_FFFE, 1'b0, "tie_first");
        check("tie_second_ready", req_ready, 2'b10);
        tick();
        req_valid[1] = 1'b0;
        tick();
        collect(1'b1, 4'd2, 32'hF800_0000, 1'b0, "tie_second");

        // Back-pressure hold.
        set_req(1, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 4'd9);
        #1;
        wait_ready(1, "bp_ready");
        tick();
        req_valid = 2'b00;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d_valid", k), rsp_valid, 1'b1);
            check($sformatf("bp_hold%0d_result", k), rsp_result, 32'd1);
            check($sformatf("bp_hold%0d_busy", k), busy, 1'b1);
            tick();
        end
        collect(1'b1, 4'd9, 32'd1, 1'b0, "bp_done");

        // Fairness with both requesters continuously valid.
        flast = 1'b1;
        ftag[0] = 4'd0;
        ftag[1] = 4'd1;
        set_req(0, 3'd0, 7'h00, 32'd0, 32'd100, ftag[0]);
        set_req(1, 3'd0, 7'h00, 32'd1, 32'd100, ftag[1]);
        #1;
        for (int k = 0; k < 8; k++) begin
            fexp = ~flast;
            flast = fexp;
            n = 0;
            while (req_ready == 2'b00 && n < 20) begin
                tick();
                n++;
            end
            check($sformatf("fair%0d_grant", k), req_ready, fexp ? 2'b10 : 2'b01);
            ctag = req_tag[fexp];
            cin1 = req_in1[fexp];
            tick();
            ftag[fexp] = ftag[fexp] + 4'd2;
            set_req(int'(fexp), 3'd0, 7'h00, 32'(ftag[fexp]), 32'd100, ftag[fexp]);
            tick();
            collect(fexp, ctag, cin1 + 32'd100, 1'b0, $sformatf("fair%0d", k));
        end
        req_valid = 2'b00;
        tick();

        // Reset during EXEC after a requester-0 win.
        set_req(0, 3'd0, 7'h00, 32'd2, 32'd3, 4'd5);
        #1;
        wait_ready(0, "rst_ready");
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        check("rst_exec_outputs", {req_ready, rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_err, busy}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_no_rsp%0d", k), rsp_valid, 1'b0);
            tick();
        end
        set_req(0, 3'd0, 7'h00, 32'd2, 32'd3, 4'd6);
        set_req(1, 3'd0, 7'h00, 32'd4, 32'd4, 4'd7);
        #1;
        check("rst_tie_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        collect(1'b0, 4'd6, 32'd5, 1'b0, "rst_after");

        // Randomised traffic against the reference model.
        mlast = 1'b0;
        occ   = 1'b0;
        age   = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                req_valid[r]  = ($urandom_range(0, 2) != 0);
                req_funct3[r] = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0, 1:    req_funct7[r] = 7'h00;
                    2:       req_funct7[r] = 7'h20;
                    default: req_funct7[r] = 7'($urandom);
                endcase
                req_in1[r] = $urandom;
                req_in2[r] = $urandom;
                req_tag[r] = 4'($urandom);
            end
            rsp_ready = ($urandom_range(0, 1) == 1);
            #1;
            eg = (req_valid == 2'b11) ? ~mlast : (req_valid == 2'b10);
            exp_rdy = (occ || req_valid == 2'b00) ? 2'b00 : (eg ? 2'b10 : 2'b01);
            check("rand_ready", req_ready, exp_rdy);
            check("rand_rsp_valid", rsp_valid, (occ && age >= 1));
            check("rand_busy", busy, occ);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_rsp", 1'b1, 1'b0);
                end else begin
                    check("rand_id", rsp_id, q[0].id);
                    check("rand_tag", rsp_tag, q[0].tag);
                    check("rand_result", rsp_result, q[0].res);
                    check("rand_err", rsp_err, q[0].err);
                end
            end
            if (!occ && req_valid != 2'b00) begin
                e_res = ref_alu(req_funct3[eg], req_funct7[eg], req_in1[eg], req_in2[eg], e_err);
                q.push_back('{eg, req_tag[eg], e_res, e_err});
                occ   = 1'b1;
                age   = 0;
                mlast = eg;
            end else if (occ) begin
                if (age >= 1 && rsp_ready) begin
                    q.delete(0);
                    occ = 1'b0;
                end else begin
                    age++;
                end
            end
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        tick();
        tick();
        check("final_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
